// File: rtl/keypad_digit_ctrl.sv
// keypad_digit_ctrl: scans a 4x4 active-low keypad, debounces presses and
//    shifts accepted hex codes into the two display digits (value1 <- value2 <- key).
// Latency: rows pass a 2-flop synchronizer. key_valid follows DEBOUNCE_CYCLES stable
//    low samples after capture. All outputs are registered.
// Backpressure: none. Each event is a single-cycle key_valid pulse with key_code, value1
//    and value2 updated in the same cycle. The display writer samples them.
// Ports:
//    clk, reset_n      system clock, asynchronous active-low reset
//    rows[3:0]         keypad rows (active-low, asynchronous), synchronized internally
//    cols[3:0]         column drives, exactly one bit low
//    value1/value2     older/newest displayed digit
//    key_valid         one-cycle event strobe
//    key_code          code of the last accepted key
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat events every
//    REPEAT_CYCLES while a key stays held. Without the macro no repeat counter is built.

module keypad_digit_ctrl #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int REPEAT_CYCLES   = 24000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] value1,
   output logic [3:0] value2,
   output logic       key_valid,
   output logic [3:0] key_code
);

   // Elaboration-time parameter range checks
   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_digit_ctrl: SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("keypad_digit_ctrl: DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("keypad_digit_ctrl: REPEAT_CYCLES must be at least 2");
   end

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   // Fixed keypad legend, indexed by {row, col}
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Registered state
   logic [3:0]     rows_meta_q;
   logic [3:0]     rows_s_q;
   state_t         state_q,     state_d;
   logic [1:0]     ci_q,        ci_d;
   logic [1:0]     ri_q,        ri_d;
   logic [DW-1:0]  dwell_q,     dwell_d;
   logic [DBW-1:0] db_q,        db_d;
   logic [3:0]     cols_q,      cols_d;
   logic [3:0]     value1_q,    value1_d;
   logic [3:0]     value2_q,    value2_d;
   logic [3:0]     key_code_q,  key_code_d;
   logic           key_valid_q, key_valid_d;
`ifdef KEYPAD_REPEAT_EN
   logic [RW-1:0]  rep_q,       rep_d;
`endif

   // Row decode of the synchronized sample: a capture needs exactly one low row
   logic       one_low;
   logic [1:0] low_idx;
   logic       row_hi;
   logic       accept;
   logic [3:0] code;

   always_comb begin
      one_low = 1'b1;
      low_idx = 2'd0;
      case (rows_s_q)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   // Only the latched row matters once a key is captured; other rows are ignored
   assign row_hi = rows_s_q[ri_q];
   assign code   = key_map(ri_q, ci_q);

   always_comb begin
      state_d = state_q;
      ci_d    = ci_q;
      ri_d    = ri_q;
      dwell_d = dwell_q;
      db_d    = db_q;
      accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = rep_q;
`endif

      case (state_q)
         S_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (one_low) begin
                  // Column stays frozen on ci_q while the press is qualified
                  ri_d    = low_idx;
                  db_d    = '0;
                  state_d = S_DEBOUNCE;
               end else begin
                  ci_d = ci_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         S_DEBOUNCE: begin
            if (row_hi) begin
               // Bounce: resume scanning the same column from a fresh dwell
               state_d = S_SCAN;
               dwell_d = '0;
            end else if (db_q == DB_LAST) begin
               state_d = S_HELD;
               accept  = 1'b1;
               db_d    = '0;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = '0;
`endif
            end else begin
               db_d = db_q + DBW'(1);
            end
         end

         S_HELD: begin
            if (row_hi) begin
               db_d    = '0;
               state_d = S_RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_q == REP_LAST) begin
               accept = 1'b1;
               rep_d  = '0;
            end else begin
               rep_d = rep_q + RW'(1);
            end
`endif
         end

         S_RELEASE: begin
            // Any low reading restarts the release qualification; never re-arms HELD
            if (!row_hi) begin
               db_d = '0;
            end else if (db_q == DB_LAST) begin
               state_d = S_SCAN;
               ci_d    = ci_q + 2'd1;
               dwell_d = '0;
               db_d    = '0;
            end else begin
               db_d = db_q + DBW'(1);
            end
         end

         default: begin
            state_d = S_SCAN;
            dwell_d = '0;
            db_d    = '0;
         end
      endcase
   end

   // Output next-state: the digit shift and strobe happen only on an accept
   always_comb begin
      cols_d      = ~(4'b0001 << ci_d);
      key_valid_d = accept;
      key_code_d  = key_code_q;
      value1_d    = value1_q;
      value2_d    = value2_q;
      if (accept) begin
         key_code_d = code;
         value1_d   = value2_q;
         value2_d   = code;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rows_meta_q <= 4'b1111;
         rows_s_q    <= 4'b1111;
         state_q     <= S_SCAN;
         ci_q        <= 2'd0;
         ri_q        <= 2'd0;
         dwell_q     <= '0;
         db_q        <= '0;
         cols_q      <= 4'b1110;
         value1_q    <= 4'h0;
         value2_q    <= 4'h0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         rows_meta_q <= rows;
         rows_s_q    <= rows_meta_q;
         state_q     <= state_d;
         ci_q        <= ci_d;
         ri_q        <= ri_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         cols_q      <= cols_d;
         value1_q    <= value1_d;
         value2_q    <= value2_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign cols      = cols_q;
   assign value1    = value1_q;
   assign value2    = value2_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_digit_ctrl.sv
// tb_keypad_digit_ctrl: drives a simulated 4x4 keypad (rows follow the DUT's column
//    drive), compares every cycle against a timestamp-based behavioural model, and
//    pins the model with literal expectations from directed key sequences.

module tb_keypad_digit_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int REP      = 16;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] rows    = 4'hF;
   logic [3:0] cols;
   logic [3:0] value1;
   logic [3:0] value2;
   logic       key_valid;
   logic [3:0] key_code;

   keypad_digit_ctrl #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rows      (rows),
      .cols      (cols),
      .value1    (value1),
      .value2    (value2),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse = 0;
   int cyc = 0;
   int pulse_t[$];

   // Keypad: bit r*4+c set means the key at row r, column c is pressed
   logic [15:0] pressed   = 16'h0;
   logic [3:0]  force_low = 4'h0;
   int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] keypad_rows(input logic [3:0] drv, input logic [15:0] p,
                                              input logic [3:0] fl);
      logic [3:0] r_out;
      r_out = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!drv[c] && p[r*4+c]) r_out[r] = 1'b0;
      return r_out & ~fl;
   endfunction

   // ---------------- behavioural model ----------------
   // Phases are tracked by the cycle at which the current interval began; the
   // elapsed time (m_now - m_t0) is compared against the dwell/debounce lengths.
   localparam int M_SCAN = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;
   int m_mode, m_col, m_row, m_now, m_t0, m_trep;
   int m_v1, m_v2, m_kc, m_kv;
   logic [3:0] m_h1, m_h2;

   task automatic m_reset();
      m_mode = M_SCAN; m_col = 0; m_row = 0; m_now = 0; m_t0 = 0; m_trep = 0;
      m_v1 = 0; m_v2 = 0; m_kc = 0; m_kv = 0;
      m_h1 = 4'hF; m_h2 = 4'hF;
   endtask

   task automatic m_accept();
      m_v1 = m_v2;
      m_v2 = keymap[m_row*4 + m_col];
      m_kc = m_v2;
      m_kv = 1;
   endtask

   task automatic m_step();
      logic [3:0] rs;
      int age, zeros, zr;
      rs = m_h2; m_h2 = m_h1; m_h1 = rows;
      m_kv = 0;
      age = m_now - m_t0;
      case (m_mode)
         M_SCAN: if (age == SCAN_DIV - 1) begin
            zeros = 0; zr = 0;
            for (int r = 0; r < 4; r++) if (!rs[r]) begin zeros++; zr = r; end
            if (zeros == 1) begin m_row = zr; m_mode = M_PRESS; end
            else m_col = (m_col + 1) % 4;
            m_t0 = m_now + 1;
         end
         M_PRESS: begin
            if (rs[m_row]) begin m_mode = M_SCAN; m_t0 = m_now + 1; end
            else if (age == DEB - 1) begin m_accept(); m_mode = M_HELD; m_trep = m_now + 1; end
         end
         M_HELD: begin
            if (rs[m_row]) begin m_mode = M_REL; m_t0 = m_now + 1; end
`ifdef KEYPAD_REPEAT_EN
            else if (m_now - m_trep == REP - 1) begin m_accept(); m_trep = m_now + 1; end
`endif
         end
         default: begin
            if (!rs[m_row]) m_t0 = m_now + 1;
            else if (age == DEB - 1) begin
               m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_t0 = m_now + 1;
            end
         end
      endcase
      m_now++;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cyc++;
      chk("cols",      cols,      int'(4'hF & ~(4'h1 << m_col)));
      chk("value1",    value1,    m_v1);
      chk("value2",    value2,    m_v2);
      chk("key_code",  key_code,  m_kc);
      chk("key_valid", key_valid, m_kv);
      if (key_valid === 1'b1) begin
         n_pulse++;
         pulse_t.push_back(cyc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         rows = keypad_rows(cols, pressed, force_low);
      end
   endtask

   task automatic press_hold(input int key, input int hold, input int idle);
      pressed = 16'h1 << key;
      step(hold);
      pressed = 16'h0;
      step(idle);
   endtask

   initial begin
      int p0, found, k1, k2;
      step(3);
      #2 reset_n = 1'b1;
      chk("rst_cols", cols, 4'b1110);
      chk("rst_value1", value1, 0);
      chk("rst_value2", value2, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_key_valid", key_valid, 0);

      // Idle scan rotation
      step(2);  chk("idle_c0", cols, 4'b1110);
      step(4);  chk("idle_c1", cols, 4'b1101);
      step(4);  chk("idle_c2", cols, 4'b1011);
      step(4);  chk("idle_c3", cols, 4'b0111);
      step(4);  chk("idle_wrap", cols, 4'b1110);
      chk("idle_no_pulse", n_pulse, 0);

      // Key '5' = row1 col1
      p0 = n_pulse;
      pressed = 16'h1 << 5;
      step(40);
      chk("k5_cols_frozen", cols, 4'b1101);
      pressed = 16'h0;
      step(40);
      chk("k5_pulses", n_pulse - p0, 1);
      chk("k5_code", key_code, 5);
      chk("k5_value2", value2, 5);
      chk("k5_value1", value1, 0);

      // '3' (r0 c2) then 'A' (r0 c3)
      p0 = n_pulse;
      press_hold(2, 40, 40);
      press_hold(3, 40, 40);
      chk("3A_pulses", n_pulse - p0, 2);
      chk("3A_value1", value1, 3);
      chk("3A_value2", value2, 10);

      // Short glitch on r2 while column 0 is driven
      p0 = n_pulse;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (cols == 4'b1110) found = 1;
      end
      chk("glitch_c0_seen", found, 1);
      force_low = 4'b0100;
      step(5);
      force_low = 4'h0;
      step(40);
      chk("glitch_pulses", n_pulse - p0, 0);
      chk("glitch_value1", value1, 3);
      chk("glitch_value2", value2, 10);

      // Two rows low on column 2 ('3' and '6'), then '6' released
      p0 = n_pulse;
      pressed = (16'h1 << 2) | (16'h1 << 6);
      step(40);
      chk("dual_pulses", n_pulse - p0, 0);
      pressed = 16'h1 << 2;
      step(40);
      pressed = 16'h0;
      step(40);
      chk("dual_then3_pulses", n_pulse - p0, 1);
      chk("dual_then3_code", key_code, 3);
      chk("dual_then3_value1", value1, 10);

      // Reset while 'F' (r3 c2) is held
      pressed = 16'h1 << 14;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (key_valid === 1'b1) found = 1;
      end
      chk("f_first_pulse", found, 1);
      step(3);
      #2 reset_n = 1'b0;
      #1;
      chk("f_rst_cols", cols, 4'b1110);
      chk("f_rst_value1", value1, 0);
      chk("f_rst_value2", value2, 0);
      chk("f_rst_key_code", key_code, 0);
      chk("f_rst_key_valid", key_valid, 0);
      step(3);
      #2 reset_n = 1'b1;
      p0 = n_pulse;
      pulse_t.delete();
`ifdef KEYPAD_REPEAT_EN
      step(60);
      chk("f_rep_enough", (n_pulse - p0 >= 2) ? 1 : 0, 1);
      for (int i = 1; i < pulse_t.size(); i++)
         chk("f_rep_spacing", pulse_t[i] - pulse_t[i-1], REP);
      chk("f_rep_code", key_code, 15);
`else
      step(40);
      chk("f_after_rst_pulses", n_pulse - p0, 1);
      chk("f_after_rst_code", key_code, 15);
      chk("f_after_rst_value2", value2, 15);
      chk("f_after_rst_value1", value1, 0);
`endif
      pressed = 16'h0;
      step(40);

      // Randomized key activity, checked cycle by cycle against the model
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5:
               press_hold($urandom_range(0, 15), $urandom_range(20, 60), $urandom_range(15, 50));
            6, 7:
               press_hold($urandom_range(0, 15), $urandom_range(1, 12), $urandom_range(5, 30));
            8: begin
               k1 = $urandom_range(0, 15);
               k2 = (k1 + $urandom_range(1, 15)) % 16;
               pressed = (16'h1 << k1) | (16'h1 << k2);
               step($urandom_range(10, 40));
               pressed = 16'h1 << k1;
               step($urandom_range(10, 40));
               pressed = 16'h0;
               step($urandom_range(15, 40));
            end
            default: begin
               pressed = 16'h1 << $urandom_range(0, 15);
               step($urandom_range(5, 45));
               #2 reset_n = 1'b0;
               step($urandom_range(1, 3));
               #2 reset_n = 1'b1;
               step($urandom_range(10, 40));
               pressed = 16'h0;
               step($urandom_range(15, 40));
            end
         endcase
         if ($urandom_range(0, 3) == 0) begin
            force_low = 4'h1 << $urandom_range(0, 3);
            step($urandom_range(1, 6));
            force_low = 4'h0;
            step(20);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_digit_ctrl.md
# keypad_digit_ctrl

Scans a 4x4 active-low matrix keypad, debounces presses, and sequences the two hex digits shown on the dual seven-segment display. Each accepted press shifts the digits left: the older digit moves to `value1` and the new key lands in `value2`. The block sits between the keypad pins and the display writer's `value1`/`value2` inputs, sharing its `clk`. It is the only writer of the displayed digits.

## Interface
- SCAN_DIV, default 50000: clock cycles each column is driven before rows are sampled; must be ≥ 4.
- DEBOUNCE_CYCLES, default 400000: consecutive stable cycles needed to accept a press or a release; must be ≥ 2.
- REPEAT_CYCLES, default 24000000: hold time per auto-repeat. Only used with `KEYPAD_REPEAT_EN`.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rows  in  4  keypad row inputs, active-low, pulled up externally, asynchronous to `clk`
- cols  out  4  keypad column drives, active-low, exactly one bit low at all times
- value1  out  4  older digit, to display writer `value1`
- value2  out  4  newest digit, to display writer `value2`
- key_valid  out  1  one-cycle pulse per accepted key event
- key_code  out  4  hex code of the last accepted key, held until the next event

## Operation
- **Synchronizer:** `rows` passes through a 2-flop synchronizer (reset value 4'b1111) to form `rows_s`. All decisions use `rows_s` only.
- **Key map** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **SCAN**
  - `cols` drives the current column index `ci` low.
  - A dwell counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, `rows_s` is sampled:
    - Exactly one bit low: latch `ci` and the row index, clear the debounce counter, go to DEBOUNCE. The column stays frozen.
    - Zero or two or more bits low: `ci` advances ((`ci`+1) mod 4) and the dwell counter restarts.
- **DEBOUNCE**
  - Column frozen. The counter increments each cycle the latched row is low.
  - If the latched row reads high, return to SCAN with the same `ci` and dwell reset. No event is produced.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low, go to HELD and raise the accept strobe.
- **Accept** (single cycle, on entry to HELD):
  - `key_valid`=1
  - `key_code`=mapped code
  - `value1`<=`value2`
  - `value2`<=mapped code
- **HELD**
  - Column frozen. Other keys are ignored.
  - When the latched row reads high, clear the counter and go to RELEASE.
- **RELEASE**
  - The counter increments each cycle the latched row is high.
  - Any low reading clears the counter and the block stays in RELEASE. It never returns to HELD and never emits a second event.
  - At DEBOUNCE_CYCLES-1, go to SCAN with `ci` advanced by one.
- **Counters:** widths are $clog2 of their parameter, with saturation-free wrap never reached in normal operation.
- **Reset (asynchronous):**
  - state=SCAN, `ci`=0, `cols`=4'b1110
  - `value1`=`value2`=0, `key_code`=0, `key_valid`=0
  - all counters 0
- Reset asserted mid-DEBOUNCE or mid-HELD discards the pending key. No event follows deassertion until a fresh press completes debounce.

## Timing
- `cols`, `value1`, `value2`, `key_code`, and `key_valid` are all registered. No combinational path from `rows`.
- Column change: `cols` updates one cycle after dwell count SCAN_DIV-1.
- Press latency: a row held low from cycle t gives `key_valid` at worst case t + 2 (sync) + SCAN_DIV·4 + DEBOUNCE_CYCLES + 1.
- `key_valid` lasts exactly 1 cycle. `value1`, `value2`, and `key_code` change in that same cycle.
- Minimum spacing between two events without repeat: DEBOUNCE_CYCLES (press) + DEBOUNCE_CYCLES (release) + 1 sample.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter counts cycles with the row low.
  - At REPEAT_CYCLES-1 it emits another accept event with the same code, shifting the digits as usual, then restarts.
  - The repeat counter clears on entry to HELD.
- Undefined: no repeat counter is built and exactly one event is produced per press.

## Test plan
Benches use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Reset, idle → `cols` cycles 1110→1101→1011→0111 every 4 cycles; `value1`=`value2`=0; `key_valid` never 1.
- Hold key '5' (r1 on c1 low) for 40 cycles, then release → exactly one `key_valid`; `key_code`=5; `value2`=5, `value1`=0; `cols` frozen at 1101 until release debounce completes.
- Press '3' then 'A', each held 40 cycles and separated by 40 idle cycles → `value1`=3, `value2`=A; exactly two pulses.
- 5-cycle low glitch on r2 during c0 → return to SCAN; no `key_valid`; values unchanged.
- r0 and r1 both low during c2 → no capture; scanning continues. Release one row (r0 stays low) → key '3' is accepted.
- Assert `reset_n` low mid-HELD of 'F' → outputs return to their reset values immediately. After deassertion with the key still held for 40 cycles → one event with `key_code`=F. With `KEYPAD_REPEAT_EN` and REPEAT_CYCLES=16, holding 'F' for 60 cycles yields repeat pulses 16 cycles apart.
